ntt_bitrev_loader: RTL

Upstream feeder for the NTT butterfly datapath and its stage controller.
- Accepts one RING_SIZE-coefficient polynomial in natural order over a valid/ready stream and stores it in an internal buffer.
- Replays the stored polynomial as coefficient pairs in bit-reversed order, one pair per cycle, to the butterfly input muxes.
- Holds the controller's `start` high from the first pair until the downstream side reports the transform is done.

---
 rtl/ntt_bitrev_loader_if.sv | 28 ++
 rtl/ntt_bitrev_loader.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/ntt_bitrev_loader_if.sv
// Stream-in / pair-out bundle between the NTT bit-reversal loader and its neighbours.
// The slave modport is the loader; the master modport is the feeding/consuming side.
interface ntt_bitrev_loader_if #(
    parameter int RING_SIZE  = 16,
    parameter int DATA_WIDTH = 16
);
    localparam int LOG_N = $clog2(RING_SIZE);

    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  out_valid;
    logic [DATA_WIDTH-1:0] out_a;
    logic [DATA_WIDTH-1:0] out_b;
    logic [LOG_N-2:0]      out_idx;
    logic                  ntt_start;
    logic                  ntt_done;

    modport master (
        output in_valid, in_data, ntt_done,
        input  in_ready, out_valid, out_a, out_b, out_idx, ntt_start
    );

    modport slave (
        input  in_valid, in_data, ntt_done,
        output in_ready, out_valid, out_a, out_b, out_idx, ntt_start
    );
endinterface

// File: rtl/ntt_bitrev_loader.sv
// Loads a polynomial in natural order, replays it as bit-reversed coefficient pairs.
// Optional macro NTT_BITREV_LOADER_PINGPONG_EN adds a second bank so loading overlaps the transform.
module ntt_bitrev_loader #(
    parameter int RING_SIZE  = 16,
    parameter int DATA_WIDTH = 16
) (
    input  logic               clk,
    input  logic               reset,
    ntt_bitrev_loader_if.slave bus
);
    localparam int LOG_N = $clog2(RING_SIZE);
    localparam int HALF  = RING_SIZE / 2;
`ifdef NTT_BITREV_LOADER_PINGPONG_EN
    localparam int AW = LOG_N + 1;
`else
    localparam int AW = LOG_N;
`endif

    typedef enum logic [1:0] {ST_LOAD, ST_DRAIN, ST_BUSY} state_t;

    state_t                r_state;
    logic [DATA_WIDTH-1:0] r_buf [2**AW];
    logic [LOG_N-1:0]      r_wcnt;
    logic [LOG_N-2:0]      r_rcnt;
    logic                  r_out_valid;
    logic [DATA_WIDTH-1:0] r_out_a;
    logic [DATA_WIDTH-1:0] r_out_b;
    logic [LOG_N-2:0]      r_out_idx;
    logic                  r_ntt_start;

    logic                  w_in_ready;
    logic                  w_hs;
    logic                  w_last_wr;
    logic [LOG_N-1:0]      w_idx_a;
    logic [LOG_N-1:0]      w_idx_b;
    logic [AW-1:0]         w_wr_addr;
    logic [AW-1:0]         w_rd_a;
    logic [AW-1:0]         w_rd_b;

    function automatic logic [LOG_N-1:0] bitrev(input logic [LOG_N-1:0] v);
        logic [LOG_N-1:0] r;
        for (int i = 0; i < LOG_N; i++) begin
            r[i] = v[LOG_N-1-i];
        end
        return r;
    endfunction

    assign w_hs      = bus.in_valid & w_in_ready;
    assign w_last_wr = (r_wcnt == LOG_N'(RING_SIZE - 1));
    assign w_idx_a   = bitrev({r_rcnt, 1'b0});
    assign w_idx_b   = bitrev({r_rcnt, 1'b1});

`ifdef NTT_BITREV_LOADER_PINGPONG_EN
    logic       r_load_bank;
    logic       r_drain_bank;
    logic [1:0] r_full;
    logic       w_pending;

    assign w_in_ready = ~r_full[r_load_bank];
    assign w_wr_addr  = {r_load_bank, r_wcnt};
    assign w_rd_a     = {r_drain_bank, w_idx_a};
    assign w_rd_b     = {r_drain_bank, w_idx_b};
    // A load finishing on the very ntt_done edge still counts as pending.
    assign w_pending  = r_full[~r_drain_bank] | (w_hs & w_last_wr);
`else
    assign w_in_ready = (r_state == ST_LOAD);
    assign w_wr_addr  = r_wcnt;
    assign w_rd_a     = w_idx_a;
    assign w_rd_b     = w_idx_b;
`endif

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (w_hs) begin
            r_buf[w_wr_addr] <= bus.in_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_LOAD;
            r_wcnt      <= '0;
            r_rcnt      <= '0;
            r_out_valid <= 1'b0;
            r_out_a     <= '0;
            r_out_b     <= '0;
            r_out_idx   <= '0;
            r_ntt_start <= 1'b0;
`ifdef NTT_BITREV_LOADER_PINGPONG_EN
            r_load_bank  <= 1'b0;
            r_drain_bank <= 1'b0;
            r_full       <= '0;
`endif
        end else begin
            // RING_SIZE is a power of two, so the write counter wraps on its own.
            if (w_hs) begin
                r_wcnt <= r_wcnt + 1'b1;
            end
`ifdef NTT_BITREV_LOADER_PINGPONG_EN
            if (w_hs && w_last_wr) begin
                r_full[r_load_bank] <= 1'b1;
                r_load_bank         <= ~r_load_bank;
            end
`endif
            case (r_state)
                ST_LOAD: begin
                    r_rcnt <= '0;
                    if (w_hs && w_last_wr) begin
                        r_state <= ST_DRAIN;
`ifdef NTT_BITREV_LOADER_PINGPONG_EN
                        r_drain_bank <= r_load_bank;
`endif
                    end
                end
                ST_DRAIN: begin
                    r_out_valid <= 1'b1;
                    r_out_a     <= r_buf[w_rd_a];
                    r_out_b     <= r_buf[w_rd_b];
                    r_out_idx   <= r_rcnt;
                    r_ntt_start <= 1'b1;
                    r_rcnt      <= r_rcnt + 1'b1;
                    if (r_rcnt == (LOG_N-1)'(HALF - 1)) begin
                        r_state <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    r_out_valid <= 1'b0;
                    if (bus.ntt_done) begin
                        r_ntt_start <= 1'b0;
`ifdef NTT_BITREV_LOADER_PINGPONG_EN
                        r_full[r_drain_bank] <= 1'b0;
                        if (w_pending) begin
                            r_state      <= ST_DRAIN;
                            r_drain_bank <= ~r_drain_bank;
                            r_rcnt       <= '0;
                        end else begin
                            r_state <= ST_LOAD;
                        end
`else
                        r_state <= ST_LOAD;
`endif
                    end
                end
                default: r_state <= ST_LOAD;
            endcase
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_a     = r_out_a;
    assign bus.out_b     = r_out_b;
    assign bus.out_idx   = r_out_idx;
    assign bus.ntt_start = r_ntt_start;
endmodule
